uart_tx_fifo: RTL
=================

# uart_tx_fifo

Byte buffer and launch sequencer directly upstream of the UART transmitter. Accepts bytes on an AXI-Stream slave with backpressure, stores up to DEPTH of them, and feeds them one at a time to the transmitter's tdata/tvalid input. The transmitter's tvalid has no tready, so this block issues a one-cycle tvalid pulse only when the transmitter is idle, then tracks its busy flag until the frame ends.

## Interface
- DEPTH, 16, FIFO capacity in bytes; power of two, ≥ 2
- BUSY_TIMEOUT, 4, cycles to wait in WAIT_BUSY for tx_busy to rise before abandoning the launch; ≥ 2
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- s_axis_tdata  in  8  byte to transmit
- s_axis_tvalid  in  1  upstream byte valid
- s_axis_tready  out  1  FIFO can accept a byte
- m_tx_tdata  out  8  byte presented to the transmitter
- m_tx_tvalid  out  1  one-cycle launch pulse to the transmitter
- tx_busy  in  1  transmitter busy flag (high while a frame is in flight)
- fifo_count  out  $clog2(DEPTH)+1  bytes currently stored
- launch_err  out  1  one-cycle pulse: launch abandoned after timeout

## Operation
- Storage: circular buffer, write/read pointers $clog2(DEPTH) bits, wrap naturally at DEPTH. Separate count register, range 0..DEPTH.
- Push: s_axis_tvalid && s_axis_tready. s_axis_tready = (count != DEPTH), forced 0 while rst_n is low.
- Pop: occurs on the IDLE→LAUNCH transition. The head byte is registered into m_tx_tdata in the same edge.
- Push and pop in the same cycle: count is unchanged, and both pointers advance. Push when full is impossible because tready is 0.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if count != 0 and tx_busy == 0 → LAUNCH (pop). Otherwise stay.
  - LAUNCH: m_tx_tvalid = 1 for exactly this cycle. Always → WAIT_BUSY, timeout counter cleared.
  - WAIT_BUSY: if tx_busy == 1 → WAIT_DONE. Else if the timer reaches BUSY_TIMEOUT-1 → IDLE with a launch_err pulse; the popped byte is dropped and not retried. Else increment the timer.
  - WAIT_DONE: if tx_busy == 0 → IDLE. Otherwise stay.
- m_tx_tvalid is decoded from state (state == LAUNCH) with no combinational path from inputs.
- m_tx_tdata holds its value until the next launch.
- Upstream pushes are accepted in every state; FSM state does not gate tready.

## Timing
- Reset (rst_n low at a clk edge):
  - state → IDLE; pointers, count, and timer → 0.
  - m_tx_tdata = 0x00, m_tx_tvalid = 0, launch_err = 0, fifo_count = 0, s_axis_tready = 0.
  - s_axis_tready reads 1 from the first cycle after rst_n rises.
- Reset mid-frame: FIFO contents are discarded and the FSM returns to IDLE. IDLE will not launch until tx_busy is low, so an in-flight transmitter frame completes unharmed.
- Latency, byte pushed at edge 0 into an empty FIFO with the transmitter idle:
  - fifo_count = 1 after edge 0.
  - LAUNCH (m_tx_tvalid = 1) after edge 1.
  - WAIT_BUSY after edge 2; the transmitter shows busy in this cycle.
  - WAIT_DONE after edge 3.
- Back-to-back frames: after tx_busy falls, 1 cycle to IDLE, then LAUNCH on the next edge. The inter-frame line-idle gap is 2 clk cycles plus the transmitter's own turnaround.
- fifo_count reflects all pushes and pops through the previous edge (registered).
- launch_err is high for exactly one cycle, coincident with the WAIT_BUSY→IDLE edge result.

## Test plan
- Single byte: push 0xA5 with the transmitter model idle → m_tx_tvalid is high for exactly 1 cycle, 2 cycles after the push edge, with m_tx_tdata = 0xA5. FSM reaches WAIT_DONE until tx_busy drops. fifo_count goes 1→0.
- Fill and backpressure: hold tx_busy = 1 and push 0x00..0x0F (DEPTH = 16) → s_axis_tready = 0 with fifo_count = 16. A 17th byte is not accepted. After tx_busy is released, bytes emerge in order 0x00..0x0F with no loss.
- Simultaneous push/pop: with count = 3, push in the same cycle as the IDLE→LAUNCH edge → count stays 3, and the pointers wrap correctly across index 15→0 over 20 bytes.
- Timeout: the transmitter model never raises tx_busy after the launch pulse → launch_err pulses once, BUSY_TIMEOUT cycles after LAUNCH, the FSM returns to IDLE, and the next byte launches normally.
- Reset mid-operation: 5 bytes queued and tx_busy = 1, pulse rst_n low for 1 cycle → fifo_count = 0, no m_tx_tvalid ever for the discarded bytes, and s_axis_tready = 1 the cycle after release.
- End-to-end with real uart_tx (NCLKS_PER_BIT = 4): push "HI" (0x48, 0x49) → serial line decodes 0x48 then 0x49, each frame is 10 bits × 4 cycles, and there are no overlapping frames.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus launch sequencer feeding a UART transmitter.
// Ports: clk/rst_n, s_axis_* byte input, m_tx_* launch output, tx_busy,
//        fifo_count occupancy, launch_err timeout pulse.
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [7:0]               m_tx_tdata,
  output logic                     m_tx_tvalid,
  input  logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     launch_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [TW-1:0] timer;
  logic          push;
  logic          pop;

  // Held low in reset so upstream never sees a stale full/empty view.
  assign s_axis_tready = rst_n && (count != FULL);
  assign push          = s_axis_tvalid && s_axis_tready;
  // Pop only when the transmitter is idle; this is the IDLE->LAUNCH edge.
  assign pop           = (state == IDLE) && (count != '0) && !tx_busy;
  assign m_tx_tvalid   = (state == LAUNCH);
  assign fifo_count    = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      m_tx_tdata <= 8'h00;
      launch_err <= 1'b0;
    end else begin
      launch_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state      <= LAUNCH;
            m_tx_tdata <= mem[rd_ptr];
          end
        end
        LAUNCH: begin
          state <= WAIT_BUSY;
          timer <= '0;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (timer == TMAX) begin
            // Transmitter never took the byte; drop it, no retry.
            state      <= IDLE;
            launch_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
